serial_ram_loader: RTL and testbench

- Write-side counterpart of the title/RAM reader path: parses a byte-command stream from the serial Receiver and writes 16-bit words into the shared RAM.
- Lets a host PC load title screens and game tables over the UART.
- Sits between Receiver (rxData/rxReady) and RAM (write port), and answers each command with an ACK/NAK byte through the Messenger (txData/txSend/txReady).

---
 rtl/serial_ram_loader_pkg.sv | 21 ++
 rtl/serial_ram_loader_if.sv | 27 ++
 rtl/serial_ram_loader_sync_edge.sv | 49 ++++
 rtl/serial_ram_loader.sv | 184 ++++++++++++++++++
 tb/tb_serial_ram_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_ram_loader_pkg.sv
// Shared definitions for the serial RAM loader and the TitleDrawer side:
// FSM state encoding, command opcodes and reply bytes.
package serial_ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_H = 3'd1,
    ADDR_L = 3'd2,
    COUNT  = 3'd3,
    DATA_H = 3'd4,
    DATA_L = 3'd5,
    WRITE  = 3'd6,
    REPLY  = 3'd7
  } loaderState_e;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_BURST    = 8'h42;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

endpackage

// File: rtl/serial_ram_loader_if.sv
// Bus bundle between the loader (master) and the Receiver / RAM write port /
// Messenger (slave).
interface serial_ram_loader_if;

  logic [7:0]  rxData;
  logic        rxReady;
  logic        ramEnable;
  logic        ramWrite;
  logic [15:0] ramAddr;
  logic [15:0] ramDataW;
  logic [7:0]  txData;
  logic        txSend;
  logic        txReady;

  // rxReady: each rising edge offers one byte, rxData stable while high.
  // txSend/txReady: txSend and txData are held until txReady falls (accepted).
  modport master (
    input  rxData, rxReady, txReady,
    output ramEnable, ramWrite, ramAddr, ramDataW, txData, txSend
  );

  modport slave (
    output rxData, rxReady, txReady,
    input  ramEnable, ramWrite, ramAddr, ramDataW, txData, txSend
  );

endinterface

// File: rtl/serial_ram_loader_sync_edge.sv
// Multi-flop synchronizer for BCLK-domain levels, plus a variant that adds a
// rising-edge pulse on the synchronized level.
module sync_flops #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= STAGES'({chain, d});
    end

    assign q = chain[STAGES-1];

endmodule

module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic prev;

    sync_flops #(.STAGES(STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/serial_ram_loader.sv
// Parses 'W'/'B' byte commands from the Receiver, writes 16-bit words into RAM
// and answers ACK/NAK via the Messenger. Optional macro: LOADER_TIMEOUT_EN.
module serial_ram_loader
  import serial_ram_loader_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  ACK_BYTE    = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE    = NAK_DEFAULT
`ifdef LOADER_TIMEOUT_EN
   ,parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET,
    serial_ram_loader_if.master  bus,
    output logic                 busy,
    output logic [15:0]          wordCount,
    output loaderState_e         dbgState
);

    loaderState_e state, stateNxt;
    logic         burst, burstNxt;
    logic [15:0]  addrReg, addrNxt;
    logic [7:0]   dataHReg, dataHNxt;
    logic [8:0]   remaining, remNxt;
    logic [7:0]   replyByte, replyNxt;
    logic         weQ, weNxt;
    logic [15:0]  ramAddrQ, ramAddrNxt, ramDataQ, ramDataNxt;
    logic [7:0]   txDataQ, txDataNxt;
    logic         txSendQ, txSendNxt;
    logic [15:0]  wordCountQ, wordNxt;
    logic         rxLevel, rxStrobe, txReadySync, timedOut;

    sync_edge #(.STAGES(SYNC_STAGES)) u_rxSync (
        .clk   (CLK),
        .rst   (RESET),
        .d     (bus.rxReady),
        .level (rxLevel),
        .rise  (rxStrobe)
    );

    sync_flops #(.STAGES(SYNC_STAGES)) u_txSync (
        .clk (CLK),
        .rst (RESET),
        .d   (bus.txReady),
        .q   (txReadySync)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [23:0] gapCnt;
    logic        inField;

    assign inField = state inside {ADDR_H, ADDR_L, COUNT, DATA_H, DATA_L};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                        gapCnt <= '0;
        else if (rxStrobe || !inField)    gapCnt <= '0;
        else if (gapCnt != TIMEOUT_CYCLES) gapCnt <= gapCnt + 24'd1;
    end

    // A byte arriving on the deadline cycle still wins over the timeout.
    assign timedOut = inField && !rxStrobe && (gapCnt == TIMEOUT_CYCLES);
`else
    assign timedOut = 1'b0;
`endif

    always_comb begin
        stateNxt   = state;
        burstNxt   = burst;
        addrNxt    = addrReg;
        dataHNxt   = dataHReg;
        remNxt     = remaining;
        replyNxt   = replyByte;
        weNxt      = 1'b0;
        ramAddrNxt = ramAddrQ;
        ramDataNxt = ramDataQ;
        txDataNxt  = txDataQ;
        txSendNxt  = txSendQ;
        wordNxt    = wordCountQ;
        case (state)
            IDLE: if (rxStrobe) begin
                if (bus.rxData == OP_WRITE) begin
                    burstNxt = 1'b0;
                    stateNxt = ADDR_H;
                end else if (bus.rxData == OP_BURST) begin
                    burstNxt = 1'b1;
                    stateNxt = ADDR_H;
                end else begin
                    replyNxt = NAK_BYTE;
                    stateNxt = REPLY;
                end
            end
            ADDR_H: if (rxStrobe) begin
                addrNxt[15:8] = bus.rxData;
                stateNxt      = ADDR_L;
            end
            ADDR_L: if (rxStrobe) begin
                addrNxt[7:0] = bus.rxData;
                stateNxt     = burst ? COUNT : DATA_H;
            end
            COUNT: if (rxStrobe) begin
                remNxt   = (bus.rxData == 8'd0) ? 9'd256 : {1'b0, bus.rxData};
                stateNxt = DATA_H;
            end
            DATA_H: if (rxStrobe) begin
                dataHNxt = bus.rxData;
                stateNxt = DATA_L;
            end
            DATA_L: if (rxStrobe) begin
                // RAM outputs are registered, so they are valid exactly in WRITE.
                weNxt      = 1'b1;
                ramAddrNxt = addrReg;
                ramDataNxt = {dataHReg, bus.rxData};
                stateNxt   = WRITE;
            end
            WRITE: begin
                wordNxt = wordCountQ + 16'd1;
                if (burst && remaining > 9'd1) begin
                    remNxt   = remaining - 9'd1;
                    addrNxt  = addrReg + 16'd1;
                    stateNxt = DATA_H;
                end else begin
                    replyNxt = ACK_BYTE;
                    stateNxt = REPLY;
                end
            end
            REPLY: begin
                if (!txSendQ && txReadySync) begin
                    txSendNxt = 1'b1;
                    txDataNxt = replyByte;
                end else if (txSendQ && !txReadySync) begin
                    txSendNxt = 1'b0;
                    stateNxt  = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
        if (timedOut) begin
            replyNxt = NAK_BYTE;
            stateNxt = REPLY;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            burst      <= 1'b0;
            addrReg    <= '0;
            dataHReg   <= '0;
            remaining  <= '0;
            replyByte  <= '0;
            weQ        <= 1'b0;
            ramAddrQ   <= '0;
            ramDataQ   <= '0;
            txDataQ    <= '0;
            txSendQ    <= 1'b0;
            wordCountQ <= '0;
        end else begin
            state      <= stateNxt;
            burst      <= burstNxt;
            addrReg    <= addrNxt;
            dataHReg   <= dataHNxt;
            remaining  <= remNxt;
            replyByte  <= replyNxt;
            weQ        <= weNxt;
            ramAddrQ   <= ramAddrNxt;
            ramDataQ   <= ramDataNxt;
            txDataQ    <= txDataNxt;
            txSendQ    <= txSendNxt;
            wordCountQ <= wordNxt;
        end
    end

    assign bus.ramEnable = weQ;
    assign bus.ramWrite  = weQ;
    assign bus.ramAddr   = ramAddrQ;
    assign bus.ramDataW  = ramDataQ;
    assign bus.txData    = txDataQ;
    assign bus.txSend    = txSendQ;
    assign busy          = (state != IDLE);
    assign wordCount     = wordCountQ;
    assign dbgState      = state;

endmodule

// File: tb/tb_serial_ram_loader.sv
// Randomized bench for serial_ram_loader: a host driver, a Messenger model and
// a scoreboard of expected RAM writes and reply bytes.
module tb_serial_ram_loader;
    import serial_ram_loader_pkg::*;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int WAIT_LIMIT = 3000;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         busy;
    logic [15:0]  wordCount;
    loaderState_e dbgState;

    serial_ram_loader_if bus();

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  rep_q[$];
    logic [7:0]  byteQ[$];
    logic [15:0] modelWords = 16'd0;
    int          writesSeen = 0;
    logic [31:0] lastWrite = 32'd0;
    logic [7:0]  lastReply = 8'd0;
    logic        txSendPrev = 1'b0;
    logic [31:0] expW;
    logic [7:0]  expR;
    int          mt;

`ifdef LOADER_TIMEOUT_EN
    serial_ram_loader #(.TIMEOUT_CYCLES(24'd1000)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.master),
        .busy(busy), .wordCount(wordCount), .dbgState(dbgState));
`else
    serial_ram_loader dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.master),
        .busy(busy), .wordCount(wordCount), .dbgState(dbgState));
`endif

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        RESET = 1'b1;
        bus.rxReady = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic checkIdleOutputs(input string nm);
        chk({nm, "_ramEnable"}, 32'(bus.ramEnable), 32'd0);
        chk({nm, "_ramWrite"},  32'(bus.ramWrite),  32'd0);
        chk({nm, "_ramAddr"},   32'(bus.ramAddr),   32'd0);
        chk({nm, "_ramDataW"},  32'(bus.ramDataW),  32'd0);
        chk({nm, "_txData"},    32'(bus.txData),    32'd0);
        chk({nm, "_txSend"},    32'(bus.txSend),    32'd0);
        chk({nm, "_busy"},      32'(busy),          32'd0);
        chk({nm, "_wordCount"}, 32'(wordCount),     32'd0);
        chk({nm, "_state"},     32'(dbgState),      32'(IDLE));
    endtask

    // driver tasks
    task automatic sendByte(input logic [7:0] b);
        @(negedge CLK);
        bus.rxData  = b;
        bus.rxReady = 1'b1;
        repeat ($urandom_range(4, 7)) @(negedge CLK);
        bus.rxReady = 1'b0;
        bus.rxData  = 8'($urandom);
        repeat ($urandom_range(3, 6)) @(negedge CLK);
    endtask

    task automatic sendAll();
        foreach (byteQ[i]) sendByte(byteQ[i]);
        byteQ.delete();
    endtask

    task automatic waitReply(input string nm);
        int t;
        t = 0;
        while ((rep_q.size() != 0 || busy || !bus.txReady) && t < WAIT_LIMIT) begin
            @(negedge CLK);
            t++;
        end
        chk({nm, "_reply_in_time"}, 32'(t < WAIT_LIMIT), 32'd1);
        chk({nm, "_wordCount"}, 32'(wordCount), 32'(modelWords));
    endtask

    task automatic cmdWrite(input logic [15:0] a, input logic [15:0] d, input string nm);
        byteQ.push_back(8'h57);
        byteQ.push_back(a[15:8]);
        byteQ.push_back(a[7:0]);
        byteQ.push_back(d[15:8]);
        byteQ.push_back(d[7:0]);
        exp_q.push_back({a, d});
        rep_q.push_back(ACK);
        modelWords += 16'd1;
        sendAll();
        waitReply(nm);
    endtask

    task automatic cmdBurst(input logic [15:0] a, input logic [7:0] c, input bit seqData,
                            input string nm);
        int n;
        logic [15:0] d;
        n = (c == 8'd0) ? 256 : int'(c);
        byteQ.push_back(8'h42);
        byteQ.push_back(a[15:8]);
        byteQ.push_back(a[7:0]);
        byteQ.push_back(c);
        for (int i = 0; i < n; i++) begin
            d = seqData ? 16'(i + 1) : 16'($urandom);
            byteQ.push_back(d[15:8]);
            byteQ.push_back(d[7:0]);
            exp_q.push_back({a + 16'(i), d});
        end
        rep_q.push_back(ACK);
        modelWords += 16'(n);
        sendAll();
        waitReply(nm);
    endtask

    task automatic cmdBad(input logic [7:0] op, input string nm);
        byteQ.push_back(op);
        rep_q.push_back(NAK);
        sendAll();
        waitReply(nm);
    endtask

    // Messenger model: goes busy when a reply is requested, idle again later.
    initial begin
        bus.txReady = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus.txSend === 1'b1) begin
                bus.txReady = 1'b0;
                mt = 0;
                while (bus.txSend === 1'b1 && mt < 100) begin
                    @(negedge CLK);
                    mt++;
                end
                if (mt >= 100) begin
                    checks++;
                    failures++;
                    $display("FAIL txSend_release actual=held required=dropped");
                end
                repeat ($urandom_range(1, 5)) @(negedge CLK);
                bus.txReady = 1'b1;
            end
        end
    end

    // scoreboard
    always @(negedge CLK) begin
        if (RESET) begin
            txSendPrev = 1'b0;
        end else begin
            chk("ramWrite_with_enable", 32'(bus.ramWrite), 32'(bus.ramEnable));
            if (bus.ramEnable) begin
                writesSeen++;
                lastWrite = {bus.ramAddr, bus.ramDataW};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%h required=none", lastWrite);
                end else begin
                    expW = exp_q.pop_front();
                    chk("ram_write", lastWrite, expW);
                end
            end
            if (bus.txSend && !txSendPrev) begin
                lastReply = bus.txData;
                if (rep_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_reply actual=%h required=none", bus.txData);
                end else begin
                    expR = rep_q.pop_front();
                    chk("reply_byte", 32'(bus.txData), 32'(expR));
                end
            end
            txSendPrev = bus.txSend;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] a;
        int          wBefore;
        bus.rxData  = 8'd0;
        bus.rxReady = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checkIdleOutputs("reset");

        cmdWrite(16'h0123, 16'hBEEF, "single");
        chk("single_write_literal", lastWrite, 32'h0123BEEF);
        chk("single_ack_literal", 32'(lastReply), 32'h06);
        chk("single_count_literal", 32'(wordCount), 32'd1);

        cmdBurst(16'hFFFE, 8'd3, 1'b1, "wrap");
        chk("wrap_last_literal", lastWrite, 32'h00000003);
        chk("wrap_count_literal", 32'(wordCount), 32'd4);

        cmdBurst(16'h1000, 8'd0, 1'b0, "burst256");
        chk("burst256_last_addr", 32'(lastWrite[31:16]), 32'h10FF);
        chk("burst256_count_literal", 32'(wordCount), 32'd260);

        wBefore = writesSeen;
        cmdBad(8'h5A, "bad");
        chk("bad_nak_literal", 32'(lastReply), 32'h15);
        chk("bad_no_write", 32'(writesSeen), 32'(wBefore));
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_state", 32'(dbgState), 32'(IDLE));

        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: cmdWrite(16'($urandom), 16'($urandom), "rnd_write");
                5, 6, 7: begin
                    a = ($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 4))
                                                    : 16'($urandom);
                    cmdBurst(a, 8'($urandom_range(1, 6)), 1'b0, "rnd_burst");
                end
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h57 || op == 8'h42) op = 8'($urandom);
                    cmdBad(op, "rnd_bad");
                end
            endcase
        end

        wBefore = writesSeen;
        byteQ.push_back(8'h57);
        byteQ.push_back(8'h00);
        byteQ.push_back(8'h10);
        byteQ.push_back(8'hAB);
        sendAll();
        doReset();
        modelWords = 16'd0;
        checkIdleOutputs("midreset");
        chk("midreset_no_write", 32'(writesSeen), 32'(wBefore));
        cmdWrite(16'h0010, 16'hABCD, "after_reset");
        chk("after_reset_write_literal", lastWrite, 32'h0010ABCD);
        chk("after_reset_count_literal", 32'(wordCount), 32'd1);

        wBefore = writesSeen;
        byteQ.push_back(8'h57);
        byteQ.push_back(8'h00);
`ifdef LOADER_TIMEOUT_EN
        rep_q.push_back(NAK);
        sendAll();
        waitReply("timeout");
        chk("timeout_nak_literal", 32'(lastReply), 32'h15);
        chk("timeout_no_write", 32'(writesSeen), 32'(wBefore));
        chk("timeout_busy", 32'(busy), 32'd0);
`else
        sendAll();
        repeat (1000) @(negedge CLK);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_state", 32'(dbgState), 32'(ADDR_L));
        chk("stall_no_write", 32'(writesSeen), 32'(wBefore));
        doReset();
        modelWords = 16'd0;
        checkIdleOutputs("stall_reset");
`endif

        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("pending_replies", 32'(rep_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
